// File: rtl/gpr_pkg.sv
// Shared constants and helpers for the gpr_sb register file and its scoreboard.
package gpr_pkg;

   // Index of the hardwired-zero register.
   localparam int ZERO_REG = 0;

   // Number of registers addressed by an index of the given width.
   function automatic int gpr_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

   // Low bit of field 'port' in a packed bus of 'width'-bit fields.
   function automatic int port_lsb(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/gpr_sb_if.sv
// Bus between decode/writeback (master) and the gpr_sb register file (slave).
//
// Issue handshake: an issue transfers on a rising clk edge when
// issue_valid && issue_ready. issue_ready is combinational from issue_rd,
// wen/waddr and the busy state; issue_valid must not depend on issue_ready,
// and wen must not be derived from issue_ready.
interface gpr_sb_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NREAD      = 2
);
   logic [NREAD*ADDR_WIDTH-1:0] raddr;
   logic [NREAD*DATA_WIDTH-1:0] rdata;
   logic [NREAD-1:0]            rbusy;
   logic                        wen;
   logic [ADDR_WIDTH-1:0]       waddr;
   logic [DATA_WIDTH-1:0]       wdata;
   logic                        issue_valid;
   logic [ADDR_WIDTH-1:0]       issue_rd;
   logic                        issue_ready;
   logic                        flush;

   modport master (
      output raddr, wen, waddr, wdata, issue_valid, issue_rd, flush,
      input  rdata, rbusy, issue_ready
   );

   modport slave (
      input  raddr, wen, waddr, wdata, issue_valid, issue_rd, flush,
      output rdata, rbusy, issue_ready
   );
endinterface

// File: rtl/gpr_scoreboard.sv
// Per-register busy scoreboard: tracks one outstanding producer per register,
// gates issue, and answers busy lookups for every read port.
module gpr_scoreboard
   import gpr_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int NREAD      = 2,
   parameter int BYPASS     = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        issue_valid,
   input  logic [ADDR_WIDTH-1:0]       issue_rd,
   output logic                        issue_ready,
   input  logic                        wen,
   input  logic [ADDR_WIDTH-1:0]       waddr,
   input  logic [NREAD*ADDR_WIDTH-1:0] lookup_addr,
   output logic [NREAD-1:0]            lookup_busy
);

   localparam int                    DEPTH    = gpr_depth(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

   logic [DEPTH-1:0] busy;
   logic             wr_live;
   logic             issue_acc;

   // x0 is never written, so its busy bit stays 0 and issue to x0 is always ready.
   assign wr_live     = wen && (waddr != ZERO_IDX);
   assign issue_ready = !busy[issue_rd] || (wen && (waddr == issue_rd));
   assign issue_acc   = issue_valid && issue_ready && (issue_rd != ZERO_IDX);

   // Busy update: flush beats issue, issue beats the clearing write (later assignment wins).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
      end else if (flush) begin
         busy <= '0;
      end else begin
         if (wr_live) begin
            busy[waddr] <= 1'b0;
         end
         if (issue_acc) begin
            busy[issue_rd] <= 1'b1;
         end
      end
   end

   // Busy lookups; with BYPASS a same-cycle write shows its register as already free.
   always_comb begin
      lookup_busy = '0;
      for (int i = 0; i < NREAD; i++) begin
         if ((BYPASS != 0) && wr_live &&
             (waddr == lookup_addr[port_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH])) begin
            lookup_busy[i] = 1'b0;
         end else begin
            lookup_busy[i] = busy[lookup_addr[port_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH]];
         end
      end
   end

endmodule

// File: rtl/gpr_sb.sv
// Register file with NREAD combinational read ports, one write port,
// optional write-to-read bypass, hardwired-zero x0 and a busy scoreboard.
module gpr_sb
   import gpr_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NREAD      = 2,
   parameter int BYPASS     = 1
) (
   input  logic     clk,
   input  logic     rst,
   gpr_sb_if.slave  bus
);

   localparam int                    DEPTH    = gpr_depth(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

   logic [DATA_WIDTH-1:0]       rf [DEPTH];
   logic [NREAD*DATA_WIDTH-1:0] rdata_all;
   logic                        wr_live;

   // Writes to x0 are dropped here; rf[0] therefore stays at its reset value of 0.
   assign wr_live = bus.wen && (bus.waddr != ZERO_IDX);

   // Data array: cleared asynchronously, written on the rising edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            rf[r] <= '0;
         end
      end else if (wr_live) begin
         rf[bus.waddr] <= bus.wdata;
      end
   end

   // Read muxes with optional same-cycle forwarding of the write data.
   always_comb begin
      rdata_all = '0;
      for (int i = 0; i < NREAD; i++) begin
         if ((BYPASS != 0) && wr_live &&
             (bus.waddr == bus.raddr[port_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH])) begin
            rdata_all[port_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = bus.wdata;
         end else begin
            rdata_all[port_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
               rf[bus.raddr[port_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH]];
         end
      end
   end

   assign bus.rdata = rdata_all;

   gpr_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NREAD      (NREAD),
      .BYPASS     (BYPASS)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .flush       (bus.flush),
      .issue_valid (bus.issue_valid),
      .issue_rd    (bus.issue_rd),
      .issue_ready (bus.issue_ready),
      .wen         (bus.wen),
      .waddr       (bus.waddr),
      .lookup_addr (bus.raddr),
      .lookup_busy (bus.rbusy)
   );

endmodule

// File: tb/tb_gpr_sb.sv
// Self-checking bench for gpr_sb: one BYPASS=1 and one BYPASS=0 instance
// driven with identical stimulus and compared against a register-file model.
module tb_gpr_sb;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 2;
   localparam int NREGS = 1 << AW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- shared stimulus ----------------
   logic [NR*AW-1:0] d_raddr;
   logic             d_wen;
   logic [AW-1:0]    d_waddr;
   logic [DW-1:0]    d_wdata;
   logic             d_iv;
   logic [AW-1:0]    d_ird;
   logic             d_flush;

   gpr_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR)) if1 ();
   gpr_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR)) if0 ();

   assign if1.raddr = d_raddr;     assign if0.raddr = d_raddr;
   assign if1.wen = d_wen;         assign if0.wen = d_wen;
   assign if1.waddr = d_waddr;     assign if0.waddr = d_waddr;
   assign if1.wdata = d_wdata;     assign if0.wdata = d_wdata;
   assign if1.issue_valid = d_iv;  assign if0.issue_valid = d_iv;
   assign if1.issue_rd = d_ird;    assign if0.issue_rd = d_ird;
   assign if1.flush = d_flush;     assign if0.flush = d_flush;

   gpr_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .BYPASS(1)) u_byp1 (
      .clk (clk), .rst (rst), .bus (if1.slave)
   );
   gpr_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .BYPASS(0)) u_byp0 (
      .clk (clk), .rst (rst), .bus (if0.slave)
   );

   // ---------------- reference model ----------------
   logic [DW-1:0]    rf_m [NREGS];
   logic [NREGS-1:0] busy_m;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] ra(input int p);
      return d_raddr[p*AW +: AW];
   endfunction

   function automatic logic write_hits(input logic [AW-1:0] a);
      return d_wen && (d_waddr != 0) && (d_waddr == a);
   endfunction

   function automatic logic [DW-1:0] exp_rdata(input int p, input bit byp);
      if (ra(p) == 0) return '0;
      if (byp && write_hits(ra(p))) return d_wdata;
      return rf_m[ra(p)];
   endfunction

   function automatic logic exp_rbusy(input int p, input bit byp);
      if (ra(p) == 0) return 1'b0;
      if (byp && write_hits(ra(p))) return 1'b0;
      return busy_m[ra(p)];
   endfunction

   function automatic logic exp_ready();
      if (d_ird == 0) return 1'b1;
      return !busy_m[d_ird] || (d_wen && d_waddr == d_ird);
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NREGS; r++) rf_m[r] = '0;
      busy_m = '0;
   endtask

   // Apply one clock edge's worth of architectural effect.
   task automatic model_step();
      logic acc;
      acc = d_iv && exp_ready();
      if (d_wen && d_waddr != 0) rf_m[d_waddr] = d_wdata;
      if (d_flush) begin
         busy_m = '0;
      end else begin
         if (d_wen && d_waddr != 0) busy_m[d_waddr] = 1'b0;
         if (acc && d_ird != 0) busy_m[d_ird] = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      for (int p = 0; p < NR; p++) begin
         check_val($sformatf("%s_p%0d_rdata_b1", tag, p), 64'(if1.rdata[p*DW +: DW]), 64'(exp_rdata(p, 1'b1)));
         check_val($sformatf("%s_p%0d_rdata_b0", tag, p), 64'(if0.rdata[p*DW +: DW]), 64'(exp_rdata(p, 1'b0)));
         check_val($sformatf("%s_p%0d_rbusy_b1", tag, p), 64'(if1.rbusy[p]), 64'(exp_rbusy(p, 1'b1)));
         check_val($sformatf("%s_p%0d_rbusy_b0", tag, p), 64'(if0.rbusy[p]), 64'(exp_rbusy(p, 1'b0)));
      end
      check_val({tag, "_ready_b1"}, 64'(if1.issue_ready), 64'(exp_ready()));
      check_val({tag, "_ready_b0"}, 64'(if0.issue_ready), 64'(exp_ready()));
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input int ra0, input int ra1, input bit wen, input int waddr,
                        input logic [DW-1:0] wdata, input bit iv, input int ird, input bit fl);
      d_raddr[0 +: AW]  = AW'(ra0);
      d_raddr[AW +: AW] = AW'(ra1);
      d_wen   = wen;
      d_waddr = AW'(waddr);
      d_wdata = wdata;
      d_iv    = iv;
      d_ird   = AW'(ird);
      d_flush = fl;
   endtask

   task automatic settle(input string tag);
      #1;
      check_all(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      model_reset();
      drive(0, 0, 0, 0, '0, 0, 0, 0);
      @(negedge clk);
      settle("reset");
      check_val("reset_ready", 64'(if1.issue_ready), 64'd1);
      rst = 1'b1;

      // Reset then read: x5 written and issued, then async reset mid-cycle.
      drive(5, 0, 1, 5, 32'h1234, 0, 0, 0);
      settle("w_x5");
      tick();
      drive(5, 0, 0, 0, '0, 1, 5, 0);
      settle("x5_val");
      check_val("x5_before_rst", 64'(if1.rdata[DW-1:0]), 64'h1234);
      tick();
      drive(5, 5, 0, 0, '0, 0, 0, 0);
      settle("x5_busy");
      rst = 1'b0;
      #1;
      check_val("rst_x5_rdata_b1", 64'(if1.rdata[DW-1:0]), 64'd0);
      check_val("rst_x5_rdata_b0", 64'(if0.rdata[DW-1:0]), 64'd0);
      check_val("rst_x5_rbusy", 64'(if1.rbusy[0]), 64'd0);
      model_reset();
      check_all("rst_async");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      settle("rst_release");

      // x0 rules.
      drive(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
      settle("w_x0");
      check_val("x0_rdata_wr", 64'(if1.rdata[DW-1:0]), 64'd0);
      tick();
      drive(0, 0, 0, 0, '0, 1, 0, 0);
      settle("iss_x0");
      check_val("x0_ready", 64'(if1.issue_ready), 64'd1);
      tick();
      drive(0, 0, 0, 0, '0, 0, 0, 0);
      settle("x0_after");
      check_val("x0_rbusy", 64'(if1.rbusy[0]), 64'd0);

      // Bypass: x7 old value 0x11, then same-cycle write/read of 0xDEADBEEF.
      drive(7, 0, 1, 7, 32'h11, 0, 0, 0);
      settle("w_x7_old");
      tick();
      drive(7, 0, 1, 7, 32'hDEAD_BEEF, 0, 0, 0);
      settle("byp");
      check_val("byp1_same", 64'(if1.rdata[DW-1:0]), 64'hDEAD_BEEF);
      check_val("byp0_old", 64'(if0.rdata[DW-1:0]), 64'h11);
      tick();
      drive(7, 0, 0, 0, '0, 0, 0, 0);
      settle("byp_next");
      check_val("byp0_next", 64'(if0.rdata[DW-1:0]), 64'hDEAD_BEEF);

      // RAW / WAW on x3.
      drive(3, 0, 0, 0, '0, 1, 3, 0);
      settle("iss_x3");
      tick();
      drive(3, 0, 0, 0, '0, 1, 3, 0);
      settle("waw_x3");
      check_val("raw_x3_busy", 64'(if1.rbusy[0]), 64'd1);
      check_val("waw_x3_ready", 64'(if1.issue_ready), 64'd0);
      tick();
      drive(3, 0, 1, 3, 32'h42, 1, 3, 0);
      settle("wr_iss_x3");
      check_val("wr_iss_x3_ready", 64'(if0.issue_ready), 64'd1);
      tick();
      drive(3, 0, 0, 0, '0, 0, 0, 0);
      settle("x3_after");
      check_val("x3_data", 64'(if0.rdata[DW-1:0]), 64'h42);
      check_val("x3_busy", 64'(if0.rbusy[0]), 64'd1);

      // Flush: x1, x2, x4 busy, then flush with issue x6 and write x2=9.
      drive(1, 2, 0, 0, '0, 1, 1, 0); settle("iss_x1"); tick();
      drive(1, 2, 0, 0, '0, 1, 2, 0); settle("iss_x2"); tick();
      drive(4, 6, 0, 0, '0, 1, 4, 0); settle("iss_x4"); tick();
      drive(1, 2, 1, 2, 32'd9, 1, 6, 1);
      settle("flush");
      tick();
      drive(1, 2, 0, 0, '0, 0, 0, 0);
      settle("post_flush_a");
      check_val("flush_busy12", 64'(if1.rbusy), 64'd0);
      check_val("flush_x2", 64'(if0.rdata[2*DW-1:DW]), 64'd9);
      drive(4, 6, 0, 0, '0, 0, 0, 0);
      settle("post_flush_b");
      check_val("flush_busy46", 64'(if0.rbusy), 64'd0);

      // Two-port independence: x1 busy, x2 idle.
      drive(1, 2, 1, 1, 32'hA5A5_0001, 1, 1, 0);
      settle("two_w_iss_x1");
      tick();
      drive(1, 2, 0, 0, '0, 0, 0, 0);
      settle("two_port");
      check_val("two_rbusy", 64'(if1.rbusy), 64'b01);
      check_val("two_rdata0", 64'(if1.rdata[DW-1:0]), 64'hA5A5_0001);
      check_val("two_rdata1", 64'(if1.rdata[2*DW-1:DW]), 64'd9);

      // Randomized traffic, biased toward low registers to create hazards.
      for (int c = 0; c < 400; c++) begin
         int a0, a1, wa, rd;
         a0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS-1)) : int'($urandom_range(0, 7));
         a1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS-1)) : int'($urandom_range(0, 7));
         wa = int'($urandom_range(0, 7));
         rd = int'($urandom_range(0, 7));
         drive(a0, a1, $urandom_range(0, 1) == 1, wa, $urandom,
               $urandom_range(0, 1) == 1, rd, $urandom_range(0, 15) == 0);
         settle("rnd");
         tick();
      end

      drive(0, 0, 0, 0, '0, 0, 0, 0);
      settle("final");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
